// File: rtl/error_delta.sv
// error_delta: joins a node's product stream with a target stream and
// produces a saturated, rate-scaled error delta (target - product) on a
// valid/ready output. It also reports the sum of |error| once per epoch.
//
// Handshake semantics (all three streams): a transfer happens at a rising
// clock edge where valid && ready are both high. A producer holds valid and
// data stable until the transfer completes. The ready outputs here come
// straight from flops and never depend on the same-cycle valid inputs.
module error_delta #(
  parameter int W     = 16,
  parameter int RATE  = 0,
  parameter int EPOCH = 4,
  parameter int LW    = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          product_valid,
  input  logic [W-1:0]  product_data,
  output logic          product_ready,
  input  logic          target_valid,
  input  logic [W-1:0]  target_data,
  output logic          target_ready,
  output logic          delta_valid,
  output logic [W-1:0]  delta_data,
  input  logic          delta_ready,
  output logic          loss_valid,
  output logic [LW-1:0] loss_data
);

  localparam int CW = $clog2(EPOCH + 1);

  logic [W-1:0]        product_hold;
  logic [W-1:0]        target_hold;
  logic                product_full;
  logic                target_full;
  logic                product_take;
  logic                target_take;
  logic                fire;
  logic signed [W:0]   diff;
  logic signed [W-1:0] sat;
  logic signed [W-1:0] scaled;
  logic [W-1:0]        mag;
  logic [LW-1:0]       acc;
  logic [LW-1:0]       acc_next;
  logic [CW-1:0]       count;
  logic                epoch_done;

  assign product_take = product_valid && product_ready;
  assign target_take  = target_valid && target_ready;

  // A pair is consumed once both holds are full and the output slot is free
  // or is being drained in this same cycle.
  assign fire = product_full && target_full && (!delta_valid || delta_ready);

  // Error datapath: widen by one bit, clamp to W bits, then scale.
  always_comb begin
    diff = $signed({target_hold[W-1], target_hold})
         - $signed({product_hold[W-1], product_hold});
    if (diff[W] != diff[W-1]) begin
      sat = diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sat = diff[W-1:0];
    end
    scaled     = sat >>> RATE;
    mag        = sat[W-1] ? $unsigned(-sat) : $unsigned(sat);
    acc_next   = acc + {{(LW-W){1'b0}}, mag};
    epoch_done = (count == CW'(EPOCH - 1));
  end

  // Product hold register; ready is the registered complement of full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      product_hold  <= '0;
      product_full  <= 1'b0;
      product_ready <= 1'b1;
    end else if (fire) begin
      product_full  <= 1'b0;
      product_ready <= 1'b1;
    end else if (product_take) begin
      product_hold  <= product_data;
      product_full  <= 1'b1;
      product_ready <= 1'b0;
    end
  end

  // Target hold register; independent of the product side.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      target_hold  <= '0;
      target_full  <= 1'b0;
      target_ready <= 1'b1;
    end else if (fire) begin
      target_full  <= 1'b0;
      target_ready <= 1'b1;
    end else if (target_take) begin
      target_hold  <= target_data;
      target_full  <= 1'b1;
      target_ready <= 1'b0;
    end
  end

  // Output slot: a fire overwrites (possibly while draining), else drain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      delta_valid <= 1'b0;
      delta_data  <= '0;
    end else if (fire) begin
      delta_valid <= 1'b1;
      delta_data  <= scaled;
    end else if (delta_ready) begin
      delta_valid <= 1'b0;
    end
  end

  // Epoch loss accumulation; the report includes the closing sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      count      <= '0;
      loss_valid <= 1'b0;
      loss_data  <= '0;
    end else begin
      loss_valid <= 1'b0;
      if (fire) begin
        if (epoch_done) begin
          loss_data  <= acc_next;
          loss_valid <= 1'b1;
          acc        <= '0;
          count      <= '0;
        end else begin
          acc   <= acc_next;
          count <= count + CW'(1);
        end
      end
    end
  end

endmodule
